// File: rtl/regfile_sb.sv
// regfile_sb -- multi-port general-purpose register file with busy-bit
// scoreboard and registered write trace, for the pipelined MIPS core.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   ra / rd / rbusy      NRD packed read ports: address, data, pending-write flag
//   we0/wa0/wd0/pc0      write port 0 (enable, address, data, instruction PC)
//   we1/wa1/wd1/pc1      write port 1, wins over port 0 on an address clash
//   iss_en, iss_addr     issue: mark a destination register busy
//   busy_cnt             number of busy registers
//   trc_v, trc_*0/1      one-cycle-delayed trace of effective writes per port
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NRD      = 2,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic [31:0]           pc0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [31:0]           pc1,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       busy_cnt,
  output logic [1:0]            trc_v,
  output logic [ADDR_W-1:0]     trc_addr0,
  output logic [ADDR_W-1:0]     trc_addr1,
  output logic [DATA_W-1:0]     trc_data0,
  output logic [DATA_W-1:0]     trc_data1,
  output logic [31:0]           trc_pc0,
  output logic [31:0]           trc_pc1
);

  localparam int NREG  = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [NREG];
  logic [DATA_W-1:0] mem_d [NREG];
  logic [NREG-1:0]   busy_q, busy_d;
  logic [CNT_W-1:0]  busy_cnt_q, busy_cnt_d;
  logic [1:0]        trc_v_q, trc_v_d;
  logic [ADDR_W-1:0] trc_addr0_q, trc_addr0_d, trc_addr1_q, trc_addr1_d;
  logic [DATA_W-1:0] trc_data0_q, trc_data0_d, trc_data1_q, trc_data1_d;
  logic [31:0]       trc_pc0_q, trc_pc0_d, trc_pc1_q, trc_pc1_d;

  logic eff0, eff1, iss_eff;
  logic cnt_inc, cnt_dec0, cnt_dec1;
  logic [ADDR_W-1:0] ra_arr [NRD];

  // With ZERO_REG, anything aimed at r0 is dropped before it reaches state.
  assign eff0    = we0    && (!ZERO_REG || (wa0 != '0));
  assign eff1    = we1    && (!ZERO_REG || (wa1 != '0));
  assign iss_eff = iss_en && (!ZERO_REG || (iss_addr != '0));

  for (genvar g = 0; g < NRD; g++) begin : g_ra
    assign ra_arr[g] = ra[g*ADDR_W +: ADDR_W];
  end

  always_comb begin
    rd    = '0;
    rbusy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (ZERO_REG && (ra_arr[i] == '0)) begin
        rd[i*DATA_W +: DATA_W] = '0;
        rbusy[i]               = 1'b0;
      end else if (BYPASS && eff1 && (wa1 == ra_arr[i])) begin
        rd[i*DATA_W +: DATA_W] = wd1;
        rbusy[i]               = 1'b0;
      end else if (BYPASS && eff0 && (wa0 == ra_arr[i])) begin
        rd[i*DATA_W +: DATA_W] = wd0;
        rbusy[i]               = 1'b0;
      end else begin
        rd[i*DATA_W +: DATA_W] = mem_q[ra_arr[i]];
        rbusy[i]               = busy_q[ra_arr[i]];
      end
    end
  end

  // Port 1 is applied last so it overwrites port 0 on an address clash.
  always_comb begin
    for (int r = 0; r < NREG; r++) mem_d[r] = mem_q[r];
    if (eff0) mem_d[wa0] = wd0;
    if (eff1) mem_d[wa1] = wd1;
  end

  // Issue is applied last so it beats a same-cycle clear. The counter tracks
  // the popcount incrementally: a clear only counts if the bit was set, is not
  // re-set by the issue, and (for port 1) is not the same register as port 0.
  always_comb begin
    busy_d = busy_q;
    if (eff0)    busy_d[wa0]      = 1'b0;
    if (eff1)    busy_d[wa1]      = 1'b0;
    if (iss_eff) busy_d[iss_addr] = 1'b1;

    cnt_inc  = iss_eff && !busy_q[iss_addr];
    cnt_dec0 = eff0 && busy_q[wa0] && !(iss_eff && (iss_addr == wa0));
    cnt_dec1 = eff1 && busy_q[wa1] && !(iss_eff && (iss_addr == wa1))
               && !(eff0 && (wa0 == wa1));
    busy_cnt_d = busy_cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec0) - CNT_W'(cnt_dec1);
  end

  always_comb begin
    trc_v_d     = {eff1, eff0};
    trc_addr0_d = eff0 ? wa0 : trc_addr0_q;
    trc_data0_d = eff0 ? wd0 : trc_data0_q;
    trc_pc0_d   = eff0 ? pc0 : trc_pc0_q;
    trc_addr1_d = eff1 ? wa1 : trc_addr1_q;
    trc_data1_d = eff1 ? wd1 : trc_data1_q;
    trc_pc1_d   = eff1 ? pc1 : trc_pc1_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= '0;
      busy_q      <= '0;
      busy_cnt_q  <= '0;
      trc_v_q     <= '0;
      trc_addr0_q <= '0;
      trc_data0_q <= '0;
      trc_pc0_q   <= '0;
      trc_addr1_q <= '0;
      trc_data1_q <= '0;
      trc_pc1_q   <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) mem_q[r] <= mem_d[r];
      busy_q      <= busy_d;
      busy_cnt_q  <= busy_cnt_d;
      trc_v_q     <= trc_v_d;
      trc_addr0_q <= trc_addr0_d;
      trc_data0_q <= trc_data0_d;
      trc_pc0_q   <= trc_pc0_d;
      trc_addr1_q <= trc_addr1_d;
      trc_data1_q <= trc_data1_d;
      trc_pc1_q   <= trc_pc1_d;
    end
  end

  assign busy_cnt  = busy_cnt_q;
  assign trc_v     = trc_v_q;
  assign trc_addr0 = trc_addr0_q;
  assign trc_data0 = trc_data0_q;
  assign trc_pc0   = trc_pc0_q;
  assign trc_addr1 = trc_addr1_q;
  assign trc_data1 = trc_data1_q;
  assign trc_pc1   = trc_pc1_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb. Two instances share one stimulus stream:
//   dut0: defaults (NRD=2, BYPASS=1, ZERO_REG=1)
//   dut1: NRD=3, BYPASS=0, ZERO_REG=0
// A per-instance array model is checked every cycle, plus literal expectations.
module tb_regfile_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [4:0]  ra_s [3];
  logic [63:0] rd0;
  logic [95:0] rd1;
  logic [1:0]  rb0;
  logic [2:0]  rb1;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1, pc0, pc1;
  logic [5:0]  o_bc [2];
  logic [1:0]  o_tv [2];
  logic [4:0]  o_ta [2][2];
  logic [31:0] o_td [2][2];
  logic [31:0] o_tp [2][2];

  regfile_sb dut0 (
    .clk(clk), .reset(reset), .ra({ra_s[1], ra_s[0]}), .rd(rd0), .rbusy(rb0),
    .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(o_bc[0]), .trc_v(o_tv[0]),
    .trc_addr0(o_ta[0][0]), .trc_addr1(o_ta[0][1]),
    .trc_data0(o_td[0][0]), .trc_data1(o_td[0][1]),
    .trc_pc0(o_tp[0][0]), .trc_pc1(o_tp[0][1])
  );

  regfile_sb #(.NRD(3), .BYPASS(1'b0), .ZERO_REG(1'b0)) dut1 (
    .clk(clk), .reset(reset), .ra({ra_s[2], ra_s[1], ra_s[0]}), .rd(rd1), .rbusy(rb1),
    .we0(we0), .wa0(wa0), .wd0(wd0), .pc0(pc0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .pc1(pc1),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_cnt(o_bc[1]), .trc_v(o_tv[1]),
    .trc_addr0(o_ta[1][0]), .trc_addr1(o_ta[1][1]),
    .trc_data0(o_td[1][0]), .trc_data1(o_td[1][1]),
    .trc_pc0(o_tp[1][0]), .trc_pc1(o_tp[1][1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m_reg  [2][32];
  bit          m_busy [2][32];
  logic [1:0]  m_tv   [2];
  logic [4:0]  m_ta   [2][2];
  logic [31:0] m_td   [2][2];
  logic [31:0] m_tp   [2][2];

  function automatic bit byp(int k); return k == 0; endfunction
  function automatic bit zr(int k);  return k == 0; endfunction
  function automatic int nrd(int k); return (k == 0) ? 2 : 3; endfunction

  function automatic bit eff(int k, logic we, logic [4:0] wa);
    return we && (!zr(k) || wa != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(int k, logic [4:0] a);
    if (zr(k) && a == 5'd0) return 32'd0;
    if (byp(k) && eff(k, we1, wa1) && wa1 == a) return wd1;
    if (byp(k) && eff(k, we0, wa0) && wa0 == a) return wd0;
    return m_reg[k][a];
  endfunction

  function automatic bit exp_rbusy(int k, logic [4:0] a);
    if (zr(k) && a == 5'd0) return 1'b0;
    if (byp(k) && ((eff(k, we0, wa0) && wa0 == a) || (eff(k, we1, wa1) && wa1 == a)))
      return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic chk(string nm, int k, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model for the current inputs.
  task automatic settle();
    int pop;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < nrd(k); i++) begin
        logic [31:0] ard;
        logic        arb;
        ard = (k == 0) ? rd0[i*32 +: 32] : rd1[i*32 +: 32];
        arb = (k == 0) ? rb0[i] : rb1[i];
        chk($sformatf("rd%0d", i), k, 64'(ard), 64'(exp_rd(k, ra_s[i])));
        chk($sformatf("rbusy%0d", i), k, 64'(arb), 64'(exp_rbusy(k, ra_s[i])));
      end
      pop = 0;
      for (int r = 0; r < 32; r++) pop += int'(m_busy[k][r]);
      chk("busy_cnt", k, 64'(o_bc[k]), 64'(pop));
      chk("trc_v", k, 64'(o_tv[k]), 64'(m_tv[k]));
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("trc_addr%0d", n), k, 64'(o_ta[k][n]), 64'(m_ta[k][n]));
        chk($sformatf("trc_data%0d", n), k, 64'(o_td[k][n]), 64'(m_td[k][n]));
        chk($sformatf("trc_pc%0d", n), k, 64'(o_tp[k][n]), 64'(m_tp[k][n]));
      end
    end
  endtask

  // Clock edge: update the model from the inputs that were presented.
  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      bit e0, e1;
      e0 = eff(k, we0, wa0);
      e1 = eff(k, we1, wa1);
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          m_reg[k][r]  = '0;
          m_busy[k][r] = 1'b0;
        end
        m_tv[k] = '0;
        for (int n = 0; n < 2; n++) begin
          m_ta[k][n] = '0; m_td[k][n] = '0; m_tp[k][n] = '0;
        end
      end else begin
        if (e0) m_reg[k][wa0] = wd0;
        if (e1) m_reg[k][wa1] = wd1;
        if (e0) m_busy[k][wa0] = 1'b0;
        if (e1) m_busy[k][wa1] = 1'b0;
        if (iss_en && (!zr(k) || iss_addr != 5'd0)) m_busy[k][iss_addr] = 1'b1;
        m_tv[k] = {e1, e0};
        if (e0) begin m_ta[k][0] = wa0; m_td[k][0] = wd0; m_tp[k][0] = pc0; end
        if (e1) begin m_ta[k][1] = wa1; m_td[k][1] = wd1; m_tp[k][1] = pc1; end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    reset = 1'b0; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
  endtask

  function automatic logic [4:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  initial begin
    idle();
    reset = 1'b1;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; pc0 = '0; pc1 = '0; iss_addr = '0;
    for (int i = 0; i < 3; i++) ra_s[i] = '0;
    advance();

    // reset state
    settle();
    chk("rst_busy_cnt", 0, 64'(o_bc[0]), 64'd0);
    chk("rst_trc_v", 0, 64'(o_tv[0]), 64'd0);
    advance();

    // write r5 on port 0
    idle(); we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; pc0 = 32'h3000; ra_s[0] = 5;
    settle(); advance();
    idle(); settle();
    chk("r5_rd", 0, 64'(rd0[31:0]), 64'hDEADBEEF);
    chk("r5_trc_v", 0, 64'(o_tv[0]), 64'd1);
    chk("r5_trc_addr", 0, 64'(o_ta[0][0]), 64'd5);
    chk("r5_trc_pc", 0, 64'(o_tp[0][0]), 64'h3000);
    advance();

    // bypass vs stored-only read of r7
    we0 = 1; wa0 = 7; wd0 = 32'h1234; ra_s[0] = 7;
    settle();
    chk("byp_rd", 0, 64'(rd0[31:0]), 64'h1234);
    chk("nobyp_old", 1, 64'(rd1[31:0]), 64'h0);
    advance();
    idle(); settle();
    chk("nobyp_new", 1, 64'(rd1[31:0]), 64'h1234);
    advance();

    // both ports write r9
    we0 = 1; wa0 = 9; wd0 = 32'hAAAA; we1 = 1; wa1 = 9; wd1 = 32'hBBBB;
    settle(); advance();
    idle(); ra_s[0] = 9; settle();
    chk("dual_rd", 0, 64'(rd0[31:0]), 64'hBBBB);
    chk("dual_rd", 1, 64'(rd1[31:0]), 64'hBBBB);
    chk("dual_trc_v", 0, 64'(o_tv[0]), 64'd3);
    chk("dual_trc_d0", 0, 64'(o_td[0][0]), 64'hAAAA);
    chk("dual_trc_d1", 0, 64'(o_td[0][1]), 64'hBBBB);
    advance();

    // scoreboard: issue r3, r4, then write+issue r3
    iss_en = 1; iss_addr = 3; settle(); advance();
    iss_addr = 4; ra_s[0] = 3; settle();
    chk("iss_cnt1", 0, 64'(o_bc[0]), 64'd1);
    chk("iss_rbusy", 0, 64'(rb0[0]), 64'd1);
    advance();
    iss_addr = 3; we0 = 1; wa0 = 3; wd0 = 32'h33; settle();
    chk("iss_cnt2", 0, 64'(o_bc[0]), 64'd2);
    advance();
    idle(); settle();
    chk("iss_beats_clr_cnt", 0, 64'(o_bc[0]), 64'd2);
    chk("iss_beats_clr_rbusy", 0, 64'(rb0[0]), 64'd1);
    advance();

    // zero register
    we0 = 1; wa0 = 0; wd0 = 32'hFFFF; iss_en = 1; iss_addr = 0; ra_s[0] = 0;
    settle();
    chk("zr_rd", 0, 64'(rd0[31:0]), 64'd0);
    chk("zr_rbusy", 0, 64'(rb0[0]), 64'd0);
    advance();
    idle(); settle();
    chk("zr_cnt", 0, 64'(o_bc[0]), 64'd2);
    chk("zr_trc_v", 0, 64'(o_tv[0]), 64'd0);
    advance();

    // r1..r4 busy, r1 = 0x55, then reset
    we0 = 1; wa0 = 1; wd0 = 32'h55; settle(); advance();
    idle(); iss_en = 1; iss_addr = 1; settle(); advance();
    iss_addr = 2; settle(); advance();
    idle(); ra_s[0] = 1; settle();
    chk("pre_rst_cnt", 0, 64'(o_bc[0]), 64'd4);
    chk("pre_rst_rd", 0, 64'(rd0[31:0]), 64'h55);
    advance();
    reset = 1; we0 = 1; wa0 = 6; wd0 = 32'h66; iss_en = 1; iss_addr = 6;
    settle(); advance();
    idle(); settle();
    chk("post_rst_cnt", 0, 64'(o_bc[0]), 64'd0);
    chk("post_rst_rd", 0, 64'(rd0[31:0]), 64'd0);
    chk("post_rst_trc_v", 0, 64'(o_tv[0]), 64'd0);
    advance();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 99) == 0);
      we0      = 1'($urandom_range(0, 1));
      we1      = 1'($urandom_range(0, 2) == 0);
      wa0      = raddr();
      wa1      = raddr();
      wd0      = $urandom();
      wd1      = $urandom();
      pc0      = $urandom();
      pc1      = $urandom();
      iss_en   = 1'($urandom_range(0, 1));
      iss_addr = raddr();
      for (int i = 0; i < 3; i++) ra_s[i] = raddr();
      settle();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
